// File: rtl/rs_bank_pkg.sv
// Shared definitions for the reservation-station bank: index/count sizing
// helpers and the free-slot allocator.
package rs_bank_pkg;

  localparam int MAX_DEPTH = 16;
  localparam int IDX_W     = 4;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Scans from the top so the last hit wins, leaving the lowest free index.
  function automatic logic [IDX_W-1:0] lowest_free(input logic [MAX_DEPTH-1:0] free);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (free[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_bank_if.sv
// Dispatch, CDB snoop and issue bundle of the reservation-station bank.
// The slave modport is the bank; the master side is dispatch/CDB/FU.
interface rs_bank_if #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 2,
  parameter int DW    = 8,
  parameter int TAGW  = 4
);
  import rs_bank_pkg::*;

  localparam int CW = count_w(DEPTH);

  logic                       flush;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [DW-1:0]              disp_operand;
  logic [DW-1:0]              disp_wbs;
  logic [DW-1:0]              disp_flag;
  logic [TAGW-1:0]            disp_robid;
  logic [NSRC-1:0][TAGW-1:0]  disp_srctag;
  logic [NSRC-1:0]            disp_srcrdy;
  logic [NSRC-1:0][DW-1:0]    disp_srcval;
  logic                       cdb_valid;
  logic [TAGW-1:0]            cdb_tag;
  logic [DW-1:0]              cdb_val;
  logic                       iss_valid;
  logic                       iss_ready;
  logic [DW-1:0]              iss_operand;
  logic [DW-1:0]              iss_wbs;
  logic [DW-1:0]              iss_flag;
  logic [TAGW-1:0]            iss_robid;
  logic [NSRC-1:0][DW-1:0]    iss_srcval;
  logic                       rs_full;
  logic [CW-1:0]              rs_count;

  modport master (
    output flush, disp_valid, disp_operand, disp_wbs, disp_flag, disp_robid,
           disp_srctag, disp_srcrdy, disp_srcval, cdb_valid, cdb_tag, cdb_val,
           iss_ready,
    input  disp_ready, iss_valid, iss_operand, iss_wbs, iss_flag, iss_robid,
           iss_srcval, rs_full, rs_count
  );

  modport slave (
    input  flush, disp_valid, disp_operand, disp_wbs, disp_flag, disp_robid,
           disp_srctag, disp_srcrdy, disp_srcval, cdb_valid, cdb_tag, cdb_val,
           iss_ready,
    output disp_ready, iss_valid, iss_operand, iss_wbs, iss_flag, iss_robid,
           iss_srcval, rs_full, rs_count
  );

endinterface

// File: rtl/rs_bank_pick.sv
// Oldest-ready selector: grants the ready entry that no other ready entry
// is older than, according to the age matrix (older[j][i] = j older than i).
module rs_bank_pick #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        any
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
    any = |ready;
  end

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station: buffers dispatched micro-ops, wakes
// operands from the CDB and issues the oldest fully-ready entry to one FU.
module rs_bank import rs_bank_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 2,
  parameter int DW    = 8,
  parameter int TAGW  = 4
) (
  input  logic     clk,
  input  logic     rst,
  rs_bank_if.slave bus
);

  localparam int CW = count_w(DEPTH);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [TAGW-1:0]           robid;
    logic [DW-1:0]             operand;
    logic [DW-1:0]             wbs;
    logic [DW-1:0]             flag;
    logic [NSRC-1:0][TAGW-1:0] tag;
    logic [NSRC-1:0]           rdy;
    logic [NSRC-1:0][DW-1:0]   val;
  } entry_t;

  entry_t                      ent [DEPTH];
  entry_t                      new_ent;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [DEPTH-1:0]            ready;
  logic [DEPTH-1:0]            grant;
  logic                        any;
  logic                        full;
  logic                        disp_fire;
  logic                        iss_fire;
  logic [MAX_DEPTH-1:0]        free_vec;
  logic [IW-1:0]               widx;
  logic [CW-1:0]               count;

  always_comb begin
    free_vec             = '0;
    free_vec[DEPTH-1:0]  = ~valid;
    widx                 = IW'(lowest_free(free_vec));
    count                = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid[i] & (&ent[i].rdy);
      count    = count + CW'(valid[i]);
    end
  end

  rs_bank_pick #(.DEPTH(DEPTH)) u_pick (
    .ready (ready),
    .older (older),
    .grant (grant),
    .any   (any)
  );

  assign full           = &valid;
  assign disp_fire      = bus.disp_valid & ~full;
  assign iss_fire       = any & bus.iss_ready;
  assign bus.disp_ready = ~full;
  assign bus.rs_full    = full;
  assign bus.rs_count   = count;
  assign bus.iss_valid  = any;

  // Grant is one-hot or zero, so OR-ing the masked entries is the mux and
  // naturally drives zeros when nothing is ready.
  always_comb begin
    bus.iss_operand = '0;
    bus.iss_wbs     = '0;
    bus.iss_flag    = '0;
    bus.iss_robid   = '0;
    bus.iss_srcval  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        bus.iss_operand = bus.iss_operand | ent[i].operand;
        bus.iss_wbs     = bus.iss_wbs     | ent[i].wbs;
        bus.iss_flag    = bus.iss_flag    | ent[i].flag;
        bus.iss_robid   = bus.iss_robid   | ent[i].robid;
        bus.iss_srcval  = bus.iss_srcval  | ent[i].val;
      end
    end
  end

  // Incoming entry, with a same-cycle CDB bypass for sources still pending.
  always_comb begin
    new_ent.robid   = bus.disp_robid;
    new_ent.operand = bus.disp_operand;
    new_ent.wbs     = bus.disp_wbs;
    new_ent.flag    = bus.disp_flag;
    new_ent.tag     = bus.disp_srctag;
    new_ent.rdy     = bus.disp_srcrdy;
    new_ent.val     = bus.disp_srcval;
    for (int s = 0; s < NSRC; s++) begin
      if (!bus.disp_srcrdy[s] && bus.cdb_valid && bus.disp_srctag[s] == bus.cdb_tag) begin
        new_ent.rdy[s] = 1'b1;
        new_ent.val[s] = bus.cdb_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      older <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (bus.flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (iss_fire && grant[i]) valid[i] <= 1'b0;
        if (valid[i]) begin
          for (int s = 0; s < NSRC; s++) begin
            if (bus.cdb_valid && !ent[i].rdy[s] && ent[i].tag[s] == bus.cdb_tag) begin
              ent[i].rdy[s] <= 1'b1;
              ent[i].val[s] <= bus.cdb_val;
            end
          end
        end
      end
      // The new entry becomes younger than every entry currently valid.
      if (disp_fire) begin
        ent[widx]   <= new_ent;
        valid[widx] <= 1'b1;
        for (int j = 0; j < DEPTH; j++) older[j][widx] <= valid[j];
        older[widx] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Directed self-checking bench for rs_bank (DEPTH=4, NSRC=2, DW=8, TAGW=4).
module tb_rs_bank;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rs_bank_if #(.DEPTH(4), .NSRC(2), .DW(8), .TAGW(4)) bus ();

  rs_bank #(.DEPTH(4), .NSRC(2), .DW(8), .TAGW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Payload fields are derived from robid so each issued entry is recognisable.
  task automatic apply_stimulus(input logic [3:0] robid, input logic [1:0] srcrdy,
                                input logic [7:0] srctag, input logic [15:0] srcval);
    bus.disp_valid   = 1'b1;
    bus.disp_robid   = robid;
    bus.disp_operand = {4'hA, robid};
    bus.disp_wbs     = {4'hB, robid};
    bus.disp_flag    = {4'hC, robid};
    bus.disp_srcrdy  = srcrdy;
    bus.disp_srctag  = srctag;
    bus.disp_srcval  = srcval;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_robid = '0;
    bus.disp_operand = '0;
    bus.disp_wbs = '0;
    bus.disp_flag = '0;
    bus.disp_srctag = '0;
    bus.disp_srcrdy = '0;
    bus.disp_srcval = '0;
    bus.cdb_valid = 1'b0;
    bus.cdb_tag = '0;
    bus.cdb_val = '0;
    bus.iss_ready = 1'b0;
    repeat (2) tick();

    check_output("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
    check_output("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    check_output("rst_full", 32'(bus.rs_full), 32'd0);
    check_output("rst_count", 32'(bus.rs_count), 32'd0);
    check_output("rst_iss_srcval", 32'(bus.iss_srcval), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] step 1: ready dispatch issues next cycle");
    bus.iss_ready = 1'b1;
    apply_stimulus(4'd3, 2'b11, 8'h00, 16'h2211);
    tick();
    bus.disp_valid = 1'b0;
    check_output("t1_iss_valid", 32'(bus.iss_valid), 32'd1);
    check_output("t1_srcval", 32'(bus.iss_srcval), 32'h2211);
    check_output("t1_robid", 32'(bus.iss_robid), 32'd3);
    check_output("t1_operand", 32'(bus.iss_operand), 32'hA3);
    check_output("t1_wbs", 32'(bus.iss_wbs), 32'hB3);
    check_output("t1_flag", 32'(bus.iss_flag), 32'hC3);
    check_output("t1_count", 32'(bus.rs_count), 32'd1);
    tick();
    check_output("t1_empty_valid", 32'(bus.iss_valid), 32'd0);
    check_output("t1_empty_count", 32'(bus.rs_count), 32'd0);
    check_output("t1_empty_srcval", 32'(bus.iss_srcval), 32'd0);

    $display("[TB] step 2: CDB wakeup");
    apply_stimulus(4'd1, 2'b10, 8'h05, 16'h7700);
    tick();
    bus.disp_valid = 1'b0;
    check_output("t2_wait_valid", 32'(bus.iss_valid), 32'd0);
    check_output("t2_wait_count", 32'(bus.rs_count), 32'd1);
    tick();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = 4'd5;
    bus.cdb_val = 8'hA5;
    check_output("t2_pre_wake_valid", 32'(bus.iss_valid), 32'd0);
    tick();
    bus.cdb_valid = 1'b0;
    check_output("t2_woken_valid", 32'(bus.iss_valid), 32'd1);
    check_output("t2_woken_srcval", 32'(bus.iss_srcval), 32'h77A5);
    check_output("t2_woken_robid", 32'(bus.iss_robid), 32'd1);
    tick();
    check_output("t2_empty_valid", 32'(bus.iss_valid), 32'd0);

    $display("[TB] step 3: same-cycle bypass");
    apply_stimulus(4'd2, 2'b10, 8'h07, 16'h1000);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = 4'd7;
    bus.cdb_val = 8'h3C;
    tick();
    bus.disp_valid = 1'b0;
    bus.cdb_valid = 1'b0;
    check_output("t3_bypass_valid", 32'(bus.iss_valid), 32'd1);
    check_output("t3_bypass_srcval", 32'(bus.iss_srcval), 32'h103C);
    check_output("t3_bypass_robid", 32'(bus.iss_robid), 32'd2);
    tick();
    check_output("t3_empty_valid", 32'(bus.iss_valid), 32'd0);

    $display("[TB] step 4: fill, backpressure, drain");
    bus.iss_ready = 1'b0;
    for (int k = 8; k < 12; k++) begin
      apply_stimulus(4'(k), 2'b11, 8'h00, {8'(k), 8'(k)});
      tick();
    end
    check_output("t4_full", 32'(bus.rs_full), 32'd1);
    check_output("t4_disp_ready", 32'(bus.disp_ready), 32'd0);
    check_output("t4_count", 32'(bus.rs_count), 32'd4);
    check_output("t4_oldest_robid", 32'(bus.iss_robid), 32'd8);
    apply_stimulus(4'd12, 2'b11, 8'h00, 16'hCCCC);
    tick();
    bus.disp_valid = 1'b0;
    check_output("t4_hold_count", 32'(bus.rs_count), 32'd4);
    check_output("t4_hold_robid", 32'(bus.iss_robid), 32'd8);
    bus.iss_ready = 1'b1;
    tick();
    check_output("t4_drain1_count", 32'(bus.rs_count), 32'd3);
    check_output("t4_drain1_full", 32'(bus.rs_full), 32'd0);
    check_output("t4_drain1_disp_ready", 32'(bus.disp_ready), 32'd1);
    check_output("t4_drain1_robid", 32'(bus.iss_robid), 32'd9);
    check_output("t4_drain1_srcval", 32'(bus.iss_srcval), 32'h0909);
    tick();
    check_output("t4_drain2_robid", 32'(bus.iss_robid), 32'd10);
    tick();
    check_output("t4_drain3_robid", 32'(bus.iss_robid), 32'd11);
    tick();
    check_output("t4_drained_valid", 32'(bus.iss_valid), 32'd0);

    $display("[TB] step 5: age order over slot index");
    bus.iss_ready = 1'b0;
    apply_stimulus(4'd4, 2'b11, 8'h00, 16'h4444);
    tick();
    apply_stimulus(4'd5, 2'b10, 8'h09, 16'h5500);
    tick();
    apply_stimulus(4'd6, 2'b10, 8'h09, 16'h6600);
    tick();
    bus.disp_valid = 1'b0;
    bus.iss_ready = 1'b1;
    check_output("t5_first_robid", 32'(bus.iss_robid), 32'd4);
    tick();
    bus.iss_ready = 1'b0;
    check_output("t5_blocked_valid", 32'(bus.iss_valid), 32'd0);
    check_output("t5_blocked_count", 32'(bus.rs_count), 32'd2);
    apply_stimulus(4'd7, 2'b10, 8'h09, 16'h7700);
    tick();
    bus.disp_valid = 1'b0;
    check_output("t5_three_count", 32'(bus.rs_count), 32'd3);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = 4'd9;
    bus.cdb_val = 8'h99;
    tick();
    bus.cdb_valid = 1'b0;
    bus.iss_ready = 1'b1;
    check_output("t5_a_valid", 32'(bus.iss_valid), 32'd1);
    check_output("t5_a_robid", 32'(bus.iss_robid), 32'd5);
    check_output("t5_a_srcval", 32'(bus.iss_srcval), 32'h5599);
    tick();
    check_output("t5_b_robid", 32'(bus.iss_robid), 32'd6);
    check_output("t5_b_srcval", 32'(bus.iss_srcval), 32'h6699);
    tick();
    check_output("t5_c_robid", 32'(bus.iss_robid), 32'd7);
    tick();
    check_output("t5_empty_valid", 32'(bus.iss_valid), 32'd0);

    $display("[TB] step 6: flush with concurrent dispatch and issue");
    bus.iss_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      apply_stimulus(4'(k), 2'b11, 8'h00, 16'h1234);
      tick();
    end
    bus.disp_valid = 1'b0;
    check_output("t6_pre_count", 32'(bus.rs_count), 32'd3);
    bus.flush = 1'b1;
    bus.iss_ready = 1'b1;
    apply_stimulus(4'd13, 2'b11, 8'h00, 16'hDDDD);
    tick();
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    check_output("t6_flush_count", 32'(bus.rs_count), 32'd0);
    check_output("t6_flush_valid", 32'(bus.iss_valid), 32'd0);
    check_output("t6_flush_disp_ready", 32'(bus.disp_ready), 32'd1);
    tick();
    check_output("t6_after_count", 32'(bus.rs_count), 32'd0);

    $display("[TB] step 7: asynchronous reset mid-stream");
    bus.iss_ready = 1'b0;
    apply_stimulus(4'd14, 2'b11, 8'h00, 16'hEEEE);
    tick();
    apply_stimulus(4'd15, 2'b11, 8'h00, 16'hFFFF);
    tick();
    bus.disp_valid = 1'b0;
    check_output("t7_pre_count", 32'(bus.rs_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_output("t7_async_count", 32'(bus.rs_count), 32'd0);
    check_output("t7_async_valid", 32'(bus.iss_valid), 32'd0);
    check_output("t7_async_disp_ready", 32'(bus.disp_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_output("t7_post_count", 32'(bus.rs_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
